tone_command_decoder: RTL and testbench
=======================================

# tone_command_decoder

Parametrised acoustic command decoder for the rover's stopped/line-lost condition. It counts microphone rising edges over consecutive fixed windows and classifies each window's count into one of four frequency bands. When NUM_WINDOWS consecutive windows agree on a band, it issues a steering or reverse-toggle command on the virtual IP sensor bus. Reverse toggling is rate-limited by a hold-off timer.

## Interface
- WINDOW_CYCLES, 10000000: clock cycles per counting window (≥4).
- NUM_WINDOWS, 3: consecutive agreeing windows required for a decision (1..15).
- COUNT_W, 16: edge-counter width; counter saturates at 2^COUNT_W−1.
- BAND0_LO/BAND0_HI, 46/59: inclusive count range, band 0 (forward).
- BAND1_LO/BAND1_HI, 86/119: inclusive count range, band 1 (left).
- BAND2_LO/BAND2_HI, 181/219: inclusive count range, band 2 (right).
- BAND3_LO/BAND3_HI, 281/319: inclusive count range, band 3 (toggle reverse).
- HOLDOFF_CYCLES, 50000000: minimum cycles between reverse toggles.
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- mic_in  input  1  asynchronous microphone comparator output.
- enable  input  1  rover is stopped and waiting for detection.
- ip_sensors  input  8  [3:0] forward-mode sensors; [7:4] reverse-mode sensors.
- virtual_ip  output  4  sensor word presented to the motion controller.
- detecting  output  1  high while in the ACQUIRE or DECIDE state.
- reverse  output  1  current reverse mode.
- cmd_valid  output  1  one-cycle pulse when a command is applied.
- cmd_band  output  2  band of the last applied command; held between pulses.

## Operation
- mic_in passes through a 2-FF synchronizer and then a registered rising-edge detector. Only rising edges count.
- Active condition: enable==1 and ip_sensors==8'h00.
- The default map is ip_sensors[3:0] when reverse==0 and ip_sensors[7:4] when reverse==1.
- **IDLE** (condition false):
  - Window counter, edge counter and streak are held at 0.
  - virtual_ip is loaded with the default map every cycle.
  - Moves to ACQUIRE on the cycle the condition becomes true.
- **ACQUIRE**:
  - Window counter runs 0..WINDOW_CYCLES−1 and wraps.
  - The edge counter increments on each detected edge.
  - At the window-end cycle (counter==WINDOW_CYCLES−1), the count includes any edge at that cycle. The count is classified with the first matching band in index order 0..3; no match is NONE.
  - Streak update: if the class is NONE, streak←0. If the class equals the previous class, streak←streak+1. Otherwise streak←1.
  - If the new streak equals NUM_WINDOWS, go to DECIDE. Otherwise load virtual_ip with the default map.
  - The edge counter clears for the next window.
- **DECIDE** (exactly 1 cycle, then ACQUIRE with streak←0, previous class←NONE):
  - Band 0: virtual_ip←0110 (1001 if reverse).
  - Band 1: virtual_ip←1000 (0001 if reverse).
  - Band 2: virtual_ip←0001 (1000 if reverse).
  - Band 3 with hold-off expired: reverse←~reverse, virtual_ip←default map using the new reverse, hold-off counter←0.
  - Band 3 with hold-off not expired: virtual_ip and reverse unchanged, cmd_valid stays 0.
  - On every applied command: cmd_valid=1 and cmd_band updated.
- Hold-off counter counts up each cycle and saturates at HOLDOFF_CYCLES. "Expired" means counter==HOLDOFF_CYCLES.
- The window counter keeps running through DECIDE, so window timing is not disturbed.
- If the active condition drops in any state, go to IDLE next cycle. Partial counts and streak are discarded; reverse and the hold-off counter are preserved.

## Timing
- Reset values:
  - virtual_ip=0000, detecting=0, reverse=0, cmd_valid=0, cmd_band=00.
  - State IDLE, all counters 0.
  - Hold-off counter = HOLDOFF_CYCLES (first toggle allowed immediately).
- Edge latency: mic_in rising edge to edge-counter increment is 3 clock edges.
- If cycle E is the last cycle of the deciding window:
  - The state register shows DECIDE after edge E+1.
  - virtual_ip, reverse, cmd_valid and cmd_band update after edge E+2.
  - cmd_valid clears after edge E+3.
- On a non-deciding window end at cycle E, the default map appears after edge E+1.
- detecting follows the state register with no added latency.
- Simultaneous events: if the condition drops during DECIDE, IDLE wins and no command is applied.
- An asynchronous reset asserted mid-window clears everything immediately.

## Test plan
All scenarios use WINDOW_CYCLES=100, NUM_WINDOWS=3, bands 5–7/10–12/20–22/30–32, HOLDOFF_CYCLES=1000.

- Reset and idle: reset low then high, enable=0, ip_sensors=8'hA5 → virtual_ip=0101, detecting=0, reverse=0, cmd_valid=0.
- Forward command: enable=1, ip_sensors=0, 6 edges in each of 3 windows → one cmd_valid pulse, cmd_band=0, virtual_ip=0110 two edges after window 3 ends.
- Streak break: per-window edge counts 11, 11, 21, 21, 21 → no pulse after window 3; one pulse with cmd_band=2 and virtual_ip=0001 after window 5.
- Reverse toggle:
  - 31 edges for 3 windows → reverse=1, cmd_band=3.
  - Repeat immediately (within 1000 cycles) → no pulse, reverse stays 1.
  - Repeat after ≥1000 cycles → reverse=0.
  - Band 1 while reverse=1 → virtual_ip=0001.
- Out-of-band and saturation: 8 edges per window → no command, default map only. With COUNT_W=3 and 20 edges, the counter holds 7 → classified band 0.
- Abort: drop enable during window 3 of a valid band-0 sequence → IDLE, no pulse. A fresh 3 windows are required after re-enable.

Source files
------------

// File: rtl/tone_command_decoder.sv
// rtl/tone_command_decoder.sv - acoustic tone-band command decoder for the stopped/line-lost rover
module tone_command_decoder #(
  parameter int WINDOW_CYCLES  = 10000000,
  parameter int NUM_WINDOWS    = 3,
  parameter int COUNT_W        = 16,
  parameter int BAND0_LO       = 46,
  parameter int BAND0_HI       = 59,
  parameter int BAND1_LO       = 86,
  parameter int BAND1_HI       = 119,
  parameter int BAND2_LO       = 181,
  parameter int BAND2_HI       = 219,
  parameter int BAND3_LO       = 281,
  parameter int BAND3_HI       = 319,
  parameter int HOLDOFF_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mic_in,
  input  logic       enable,
  input  logic [7:0] ip_sensors,
  output logic [3:0] virtual_ip,
  output logic       detecting,
  output logic       reverse,
  output logic       cmd_valid,
  output logic [1:0] cmd_band
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]         CLASS_NONE = 3'd4;

  typedef enum logic [1:0] {IDLE, ACQUIRE, DECIDE} stateType;

  stateType            state, nextState;
  logic [2:0]          micSync;
  logic [WIN_W-1:0]    windowCnt;
  logic [COUNT_W-1:0]  edgeCnt, countNext;
  logic [3:0]          streak, streakNext;
  logic [2:0]          prevClass, classNow;
  logic [HOLD_W-1:0]   holdCnt;
  logic                edgeDet, active, windowEnd, deciding, holdExpired;
  logic [3:0]          defaultMap, vipCmd;
  logic                applyCmd, toggleRev, revNext;

  function automatic logic [2:0] classify(input logic [COUNT_W-1:0] c);
    logic [31:0] v;
    v = 32'(c);
    if (v >= 32'(BAND0_LO) && v <= 32'(BAND0_HI)) return 3'd0;
    if (v >= 32'(BAND1_LO) && v <= 32'(BAND1_HI)) return 3'd1;
    if (v >= 32'(BAND2_LO) && v <= 32'(BAND2_HI)) return 3'd2;
    if (v >= 32'(BAND3_LO) && v <= 32'(BAND3_HI)) return 3'd3;
    return CLASS_NONE;
  endfunction

  // micSync[1] is the synchronized level, micSync[2] its previous value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) micSync <= '0;
    else        micSync <= {micSync[1:0], mic_in};
  end

  assign edgeDet     = micSync[1] & ~micSync[2];
  assign active      = enable && (ip_sensors == 8'h00);
  assign defaultMap  = reverse ? ip_sensors[7:4] : ip_sensors[3:0];
  assign windowEnd   = (state == ACQUIRE) && (windowCnt == WIN_LAST);
  assign holdExpired = (holdCnt == HOLD_MAX);
  assign detecting   = (state == ACQUIRE) || (state == DECIDE);

  // the window-end count includes an edge arriving on that same cycle
  assign countNext = (edgeDet && edgeCnt != CNT_MAX) ? edgeCnt + 1'b1 : edgeCnt;
  assign classNow  = classify(countNext);

  always_comb begin
    streakNext = 4'd1;
    if (classNow == CLASS_NONE)     streakNext = 4'd0;
    else if (classNow == prevClass) streakNext = streak + 4'd1;
  end

  assign deciding = windowEnd && (streakNext == 4'(NUM_WINDOWS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    applyCmd  = 1'b0;
    toggleRev = 1'b0;
    revNext   = reverse;
    vipCmd    = virtual_ip;
    if (!active) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    nextState = ACQUIRE;
        ACQUIRE: if (deciding) nextState = DECIDE;
        DECIDE: begin
          nextState = ACQUIRE;
          case (prevClass[1:0])
            2'd0: begin applyCmd = 1'b1; vipCmd = reverse ? 4'b1001 : 4'b0110; end
            2'd1: begin applyCmd = 1'b1; vipCmd = reverse ? 4'b0001 : 4'b1000; end
            2'd2: begin applyCmd = 1'b1; vipCmd = reverse ? 4'b1000 : 4'b0001; end
            default: begin
              if (holdExpired) begin
                applyCmd  = 1'b1;
                toggleRev = 1'b1;
                revNext   = ~reverse;
                vipCmd    = revNext ? ip_sensors[7:4] : ip_sensors[3:0];
              end
            end
          endcase
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      windowCnt  <= '0;
      edgeCnt    <= '0;
      streak     <= '0;
      prevClass  <= CLASS_NONE;
      holdCnt    <= HOLD_MAX;
      virtual_ip <= 4'b0000;
      reverse    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_band   <= 2'b00;
    end else begin
      cmd_valid <= applyCmd;
      reverse   <= revNext;
      if (applyCmd) cmd_band <= prevClass[1:0];
      if (toggleRev)               holdCnt <= '0;
      else if (holdCnt != HOLD_MAX) holdCnt <= holdCnt + 1'b1;

      // reverse and hold-off survive an abort; everything window-related restarts
      if (state == IDLE || !active) begin
        windowCnt <= '0;
        edgeCnt   <= '0;
        streak    <= '0;
        prevClass <= CLASS_NONE;
      end else begin
        windowCnt <= (windowCnt == WIN_LAST) ? '0 : windowCnt + 1'b1;
        edgeCnt   <= windowEnd ? '0 : countNext;
        if (windowEnd) begin
          streak    <= streakNext;
          prevClass <= classNow;
        end else if (state == DECIDE) begin
          streak    <= '0;
          prevClass <= CLASS_NONE;
        end
      end

      if (state == IDLE)                          virtual_ip <= defaultMap;
      else if (applyCmd)                          virtual_ip <= vipCmd;
      else if (windowEnd && active && !deciding)  virtual_ip <= defaultMap;
    end
  end

endmodule

// File: tb/tb_tone_command_decoder.sv
// tb/tb_tone_command_decoder.sv - scoreboard bench for tone_command_decoder
module tb_tone_command_decoder;

  logic       clock = 1'b0;
  logic       reset, micIn, enable, enableSat;
  logic [7:0] ipSensors;
  logic [3:0] virtualIp, virtualIpSat;
  logic       detecting, detectingSat, reverseMode, reverseSat, cmdValid, cmdValidSat;
  logic [1:0] cmdBand, cmdBandSat;

  always #5 clock = ~clock;

  tone_command_decoder #(
    .WINDOW_CYCLES(100), .NUM_WINDOWS(3), .COUNT_W(16),
    .BAND0_LO(5), .BAND0_HI(7), .BAND1_LO(10), .BAND1_HI(12),
    .BAND2_LO(20), .BAND2_HI(22), .BAND3_LO(30), .BAND3_HI(32),
    .HOLDOFF_CYCLES(1000)
  ) dut (
    .clock(clock), .reset(reset), .mic_in(micIn), .enable(enable), .ip_sensors(ipSensors),
    .virtual_ip(virtualIp), .detecting(detecting), .reverse(reverseMode),
    .cmd_valid(cmdValid), .cmd_band(cmdBand)
  );

  tone_command_decoder #(
    .WINDOW_CYCLES(100), .NUM_WINDOWS(3), .COUNT_W(3),
    .BAND0_LO(5), .BAND0_HI(7), .BAND1_LO(10), .BAND1_HI(12),
    .BAND2_LO(20), .BAND2_HI(22), .BAND3_LO(30), .BAND3_HI(32),
    .HOLDOFF_CYCLES(1000)
  ) dutSat (
    .clock(clock), .reset(reset), .mic_in(micIn), .enable(enableSat), .ip_sensors(ipSensors),
    .virtual_ip(virtualIpSat), .detecting(detectingSat), .reverse(reverseSat),
    .cmd_valid(cmdValidSat), .cmd_band(cmdBandSat)
  );

  typedef struct {
    logic [1:0] band;
    logic [3:0] vip;
    logic       rev;
  } cmdType;

  cmdType expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount  = 0;
  int pulseMark;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input logic [1:0] band, input logic [3:0] vip, input logic rev);
    cmdType e;
    e.band = band;
    e.vip  = vip;
    e.rev  = rev;
    expQ.push_back(e);
  endtask

  always @(negedge clock) begin
    cmdType e;
    if (reset && cmdValid) begin
      pulseCount++;
      if (expQ.size() == 0) begin
        checkEq("unexpectedCmd", 32'(cmdValid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkEq("sbBand", 32'(cmdBand), 32'(e.band));
        checkEq("sbVip", 32'(virtualIp), 32'(e.vip));
        checkEq("sbRev", 32'(reverseMode), 32'(e.rev));
      end
    end
  end

  // one window of len cycles with n single-cycle mic pulses, aligned to the DUT window
  task automatic runWindow(input int n, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      micIn = (i >= 4) && (i < 4 + 2 * n) && (((i - 4) % 2) == 0);
    end
    micIn = 1'b0;
  endtask

  task automatic activate();
    @(negedge clock);
    ipSensors = 8'h00;
    enable    = 1'b1;
  endtask

  task automatic deactivate(input int cycles);
    @(negedge clock);
    enable = 1'b0;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic expectDecide(input string tag, input logic [1:0] band, input logic [3:0] vip,
                              input logic rev);
    @(negedge clock);
    checkEq({tag, "DecideDetect"}, 32'(detecting), 32'd1);
    checkEq({tag, "NotYet"}, 32'(cmdValid), 32'd0);
    @(negedge clock);
    checkEq({tag, "Valid"}, 32'(cmdValid), 32'd1);
    checkEq({tag, "Band"}, 32'(cmdBand), 32'(band));
    checkEq({tag, "Vip"}, 32'(virtualIp), 32'(vip));
    checkEq({tag, "Rev"}, 32'(reverseMode), 32'(rev));
    @(negedge clock);
    checkEq({tag, "Clear"}, 32'(cmdValid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; enableSat = 1'b0; micIn = 1'b0; ipSensors = 8'hA5;
    repeat (3) @(negedge clock);
    checkEq("rstVip", 32'(virtualIp), 32'h0);
    checkEq("rstDetect", 32'(detecting), 32'd0);
    checkEq("rstRev", 32'(reverseMode), 32'd0);
    checkEq("rstValid", 32'(cmdValid), 32'd0);
    checkEq("rstBand", 32'(cmdBand), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkEq("idleVip", 32'(virtualIp), 32'h5);
    checkEq("idleDetect", 32'(detecting), 32'd0);
    checkEq("idleValid", 32'(cmdValid), 32'd0);

    // forward
    pushExp(2'd0, 4'b0110, 1'b0);
    activate();
    repeat (3) runWindow(6, 100);
    expectDecide("fwd", 2'd0, 4'b0110, 1'b0);
    deactivate(3);

    // streak break 11,11,21,21,21
    pushExp(2'd2, 4'b0001, 1'b0);
    activate();
    runWindow(11, 100);
    runWindow(11, 100);
    pulseMark = pulseCount;
    runWindow(21, 100);
    runWindow(21, 100);
    checkEq("streakNoEarly", 32'(pulseCount), 32'(pulseMark));
    runWindow(21, 100);
    expectDecide("streak", 2'd2, 4'b0001, 1'b0);

    // asynchronous reset mid-window
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkEq("asyncDetect", 32'(detecting), 32'd0);
    checkEq("asyncBand", 32'(cmdBand), 32'd0);
    checkEq("asyncVip", 32'(virtualIp), 32'h0);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // first toggle allowed straight after reset
    pushExp(2'd3, 4'b0000, 1'b1);
    activate();
    repeat (3) runWindow(31, 100);
    expectDecide("tog1", 2'd3, 4'b0000, 1'b1);
    deactivate(1);

    // immediate repeat is held off
    activate();
    repeat (3) runWindow(31, 100);
    pulseMark = pulseCount;
    repeat (3) @(negedge clock);
    checkEq("holdNoPulse", 32'(pulseCount), 32'(pulseMark));
    checkEq("holdRev", 32'(reverseMode), 32'd1);
    deactivate(1);

    // left while reversed
    pushExp(2'd1, 4'b0001, 1'b1);
    activate();
    repeat (3) runWindow(11, 100);
    expectDecide("revLeft", 2'd1, 4'b0001, 1'b1);
    deactivate(1);
    ipSensors = 8'hA5;
    repeat (2) @(negedge clock);
    checkEq("idleRevMap", 32'(virtualIp), 32'hA);
    ipSensors = 8'h00;
    repeat (500) @(negedge clock);

    // hold-off has expired by now
    pushExp(2'd3, 4'b0000, 1'b0);
    activate();
    repeat (3) runWindow(31, 100);
    expectDecide("tog2", 2'd3, 4'b0000, 1'b0);
    deactivate(1);

    // out of band
    activate();
    repeat (3) runWindow(8, 100);
    pulseMark = pulseCount;
    repeat (3) @(negedge clock);
    checkEq("oobNoPulse", 32'(pulseCount), 32'(pulseMark));
    checkEq("oobVip", 32'(virtualIp), 32'h0);
    deactivate(1);

    // abort during window 3, then a fresh 3 windows are needed
    activate();
    runWindow(6, 100);
    runWindow(6, 100);
    runWindow(6, 50);
    pulseMark = pulseCount;
    deactivate(5);
    checkEq("abortNoPulse", 32'(pulseCount), 32'(pulseMark));
    checkEq("abortIdle", 32'(detecting), 32'd0);
    pushExp(2'd0, 4'b0110, 1'b0);
    activate();
    runWindow(6, 100);
    runWindow(6, 100);
    checkEq("abortFresh", 32'(pulseCount), 32'(pulseMark));
    runWindow(6, 100);
    expectDecide("abort", 2'd0, 4'b0110, 1'b0);
    deactivate(1);

    // 3-bit counter saturates at 7 -> band 0
    @(negedge clock);
    enableSat = 1'b1;
    repeat (3) runWindow(20, 100);
    @(negedge clock);
    checkEq("satNotYet", 32'(cmdValidSat), 32'd0);
    @(negedge clock);
    checkEq("satValid", 32'(cmdValidSat), 32'd1);
    checkEq("satBand", 32'(cmdBandSat), 32'd0);
    checkEq("satVip", 32'(virtualIpSat), 32'h6);
    @(negedge clock);
    checkEq("satClear", 32'(cmdValidSat), 32'd0);
    enableSat = 1'b0;
    repeat (3) @(negedge clock);

    checkEq("sbDrained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
